// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//
// Write-back initiator for the 32x32 register file. Write-back results from
// the execute/memory stages arrive over a valid/ready handshake and are
// buffered in a small ring-buffer FIFO. The queue drains one entry per cycle
// into the register file write port. Values that are still queued are
// forwarded to both read ports so that readers never observe stale data.
//
// Optional build macro: REGFILE_WB_HOLD_EN
//   When defined, the input drain_hold is added. While it is high the queue
//   stops committing (RegWrite=0, no pop), but enqueue and forwarding continue.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       producer handshake (in_ready = !full)
//   in_reg, in_data         destination register index and value
//   RegWrite/WriteReg/WriteData  register file write port (head of queue)
//   rd_reg1/rd_reg2         read-port indices (also driven to the reg file)
//   rf_data1/rf_data2       register file read data
//   rd_data1/rd_data2       forwarded read data
//   count, empty, full      occupancy status
//   drain_hold              (REGFILE_WB_HOLD_EN only) stall the drain side
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
  parameter int DEPTH  = 4,  // power of two, at least 2
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteReg,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        rd_reg1,
  input  logic [ADDR_W-1:0]        rd_reg2,
  input  logic [DATA_W-1:0]        rf_data1,
  input  logic [DATA_W-1:0]        rf_data2,
  output logic [DATA_W-1:0]        rd_data1,
  output logic [DATA_W-1:0]        rd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
`ifdef REGFILE_WB_HOLD_EN
  ,
  input  logic                     drain_hold
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Ring-buffer state. DEPTH is a power of two, so the pointers wrap
  // naturally when they overflow.
  logic [PTR_W-1:0]  headPtrReg, headPtrNext;
  logic [PTR_W-1:0]  tailPtrReg, tailPtrNext;
  logic [CNT_W-1:0]  countReg, countNext;

  logic [ADDR_W-1:0] entryIdxReg   [DEPTH];
  logic [DATA_W-1:0] entryDataReg  [DEPTH];
  logic              entryValidReg [DEPTH];

  logic emptyInt;
  logic fullInt;
  logic holdActive;
  logic acceptEn;
  logic pushEn;
  logic popEn;

`ifdef REGFILE_WB_HOLD_EN
  assign holdActive = drain_hold;
`else
  assign holdActive = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Status and handshake
  // ---------------------------------------------------------------------------
  assign emptyInt = (countReg == '0);
  assign fullInt  = (countReg == CNT_W'(DEPTH));

  assign count    = countReg;
  assign empty    = emptyInt;
  assign full     = fullInt;

  // No pass-through: a full queue refuses new data even on a draining cycle.
  assign in_ready = !fullInt;
  assign acceptEn = in_valid && in_ready;

  // Writes to r0 complete the handshake but are dropped; r0 is never written.
  assign pushEn   = acceptEn && (in_reg != '0);

  // The head pops on the same edge the register file samples it.
  assign popEn    = !emptyInt && !holdActive;

  // ---------------------------------------------------------------------------
  // Drain side: combinational from the head entry
  // ---------------------------------------------------------------------------
  // RegWrite is masked during reset so that pending entries are discarded
  // rather than committed on the reset edge.
  assign RegWrite  = popEn && !reset;
  assign WriteReg  = emptyInt ? '0 : entryIdxReg[headPtrReg];
  assign WriteData = emptyInt ? '0 : entryDataReg[headPtrReg];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    headPtrNext = headPtrReg;
    tailPtrNext = tailPtrReg;
    countNext   = countReg;

    if (popEn) begin
      headPtrNext = headPtrReg + PTR_W'(1);
    end
    if (pushEn) begin
      tailPtrNext = tailPtrReg + PTR_W'(1);
    end

    unique case ({pushEn, popEn})
      2'b10:   countNext = countReg + CNT_W'(1);
      2'b01:   countNext = countReg - CNT_W'(1);
      default: countNext = countReg;  // idle, or push and pop together
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      headPtrReg <= '0;
      tailPtrReg <= '0;
      countReg   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryValidReg[i] <= 1'b0;
        entryIdxReg[i]   <= '0;
        entryDataReg[i]  <= '0;
      end
    end else begin
      headPtrReg <= headPtrNext;
      tailPtrReg <= tailPtrNext;
      countReg   <= countNext;
      for (int i = 0; i < DEPTH; i++) begin
        // Push and pop never target the same slot: that would need the queue
        // to be both empty (pop) and full (push refused) at once.
        if (popEn && (headPtrReg == PTR_W'(i))) begin
          entryValidReg[i] <= 1'b0;
        end
        if (pushEn && (tailPtrReg == PTR_W'(i))) begin
          entryValidReg[i] <= 1'b1;
          entryIdxReg[i]   <= in_reg;
          entryDataReg[i]  <= in_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read forwarding, one identical instance per read port
  // ---------------------------------------------------------------------------
  // The head entry is included: the register file only picks up the write at
  // the edge, so during the commit cycle its read data is still stale.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [ADDR_W-1:0] portReg;
    logic [DATA_W-1:0] portRf;
    logic [DATA_W-1:0] portData;

    assign portReg = (gi == 0) ? rd_reg1  : rd_reg2;
    assign portRf  = (gi == 0) ? rf_data1 : rf_data2;

    always_comb begin
      logic [PTR_W-1:0] slot;
      portData = portRf;
      slot     = '0;
      // Walk slots from oldest age to newest (age 0 = just behind the tail),
      // so the last match applied is the newest pending value.
      for (int age = DEPTH - 1; age >= 0; age--) begin
        slot = tailPtrReg - PTR_W'(age) - PTR_W'(1);
        if ((portReg != '0) && entryValidReg[slot] &&
            (entryIdxReg[slot] == portReg)) begin
          portData = entryDataReg[slot];
        end
      end
    end

    if (gi == 0) begin : g_port1
      assign rd_data1 = portData;
    end else begin : g_port2
      assign rd_data2 = portData;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_queue
//
// Self-checking bench for regfile_wb_queue. A reference model (a queue of
// pending writes plus a register-file array) predicts every output each cycle.
// The bench also plays the register file: it records what the DUT actually
// writes and compares that against the model at the end.
// -----------------------------------------------------------------------------
module tb_regfile_wb_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] rd_reg1;
  logic [ADDR_W-1:0] rd_reg2;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [$clog2(DEPTH):0] count;
  logic              empty;
  logic              full;
`ifdef REGFILE_WB_HOLD_EN
  logic              drain_hold;
`endif

  always #5 clock = ~clock;

  regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .rd_reg1   (rd_reg1),
    .rd_reg2   (rd_reg2),
    .rf_data1  (rf_data1),
    .rf_data2  (rf_data2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .count     (count),
    .empty     (empty),
    .full      (full)
`ifdef REGFILE_WB_HOLD_EN
    ,
    .drain_hold(drain_hold)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              pend[$];          // pending writes, oldest at index 0
  logic [DATA_W-1:0] rfModel [32];     // expected register file contents
  logic [DATA_W-1:0] dutRf   [32];     // what the DUT actually wrote
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Newest pending value for a register, else the register file value.
  function automatic logic [DATA_W-1:0] fwdModel(input logic [ADDR_W-1:0] r,
                                                 input logic [DATA_W-1:0] rfv);
    logic [DATA_W-1:0] v;
    v = rfv;
    if (r != 0) begin
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].r == r) v = pend[i].d;
      end
    end
    return v;
  endfunction

  // One clock cycle: drive inputs, check all outputs, update model, clock.
  task automatic step(input logic v, input logic [ADDR_W-1:0] r,
                      input logic [DATA_W-1:0] d, input logic h,
                      input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    int   sz;
    logic acc;
    logic com;
    in_valid = v;
    in_reg   = r;
    in_data  = d;
`ifdef REGFILE_WB_HOLD_EN
    drain_hold = h;
`endif
    rd_reg1  = a1;
    rd_reg2  = a2;
    rf_data1 = rfModel[a1];
    rf_data2 = rfModel[a2];
    #1;
    sz = pend.size();
    check("count",     count,     64'(sz));
    check("empty",     empty,     64'(sz == 0));
    check("full",      full,      64'(sz == DEPTH));
    check("in_ready",  in_ready,  64'(sz < DEPTH));
    check("RegWrite",  RegWrite,  64'(sz > 0 && !h));
    check("WriteReg",  WriteReg,  (sz > 0) ? 64'(pend[0].r) : 64'd0);
    check("WriteData", WriteData, (sz > 0) ? 64'(pend[0].d) : 64'd0);
    check("rd_data1",  rd_data1,  64'(fwdModel(a1, rfModel[a1])));
    check("rd_data2",  rd_data2,  64'(fwdModel(a2, rfModel[a2])));
    if (RegWrite) dutRf[WriteReg] = WriteData;
    acc = v && (sz < DEPTH);
    com = (sz > 0) && !h;
    if (com) begin
      rfModel[pend[0].r] = pend[0].d;
      void'(pend.pop_front());
    end
    if (acc && r != 0) pend.push_back('{r, d});
    $display("txn cyc=%0d valid=%0b reg=%0d data=%h hold=%0b accepted=%0b committed=%0b pending=%0d",
             cyc, v, r, d, h, acc, com, pend.size());
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("RegWrite_during_reset", RegWrite, 64'd0);
    if (RegWrite) dutRf[WriteReg] = WriteData;
    @(posedge clock);
    #1;
    check("reset_count",    count,    64'd0);
    check("reset_empty",    empty,    64'd1);
    check("reset_full",     full,     64'd0);
    check("reset_in_ready", in_ready, 64'd1);
    check("reset_RegWrite", RegWrite, 64'd0);
    pend.delete();
    reset = 1'b0;
    $display("txn cyc=%0d reset pending_discarded", cyc);
    cyc++;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
    rd_reg1  = '0;
    rd_reg2  = '0;
    rf_data1 = '0;
    rf_data2 = '0;
`ifdef REGFILE_WB_HOLD_EN
    drain_hold = 1'b0;
`endif
    for (int i = 0; i < 32; i++) begin
      rfModel[i] = '0;
      dutRf[i]   = '0;
    end
    @(posedge clock);
    #1;
    doReset();

    // Single transfer: commits the cycle after acceptance.
    step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd3, 5'd0);
    step(1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd3);
    step(1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd0);
    check("r3_committed", dutRf[3], 64'hDEADBEEF);

    // Transfer to r0 is swallowed; r0 reads return the register file value.
    rfModel[0] = 32'h0BAD_0000;
    step(1'b1, 5'd0, 32'h0000FFFF, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0);
    rfModel[0] = '0;

    // Continuous stream r1..r10 with data = index.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 5'(i), 32'(i), 1'b0, 5'(i), 5'(i - 1));
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 5'd1);
    for (int i = 1; i <= 10; i++) begin
      check("stream_commit", dutRf[i], 64'(i));
    end

`ifdef REGFILE_WB_HOLD_EN
    // Fill under hold; the fifth offer must be refused.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 5'(i + 10), 32'h100 + 32'(i), 1'b1, 5'(i + 10), 5'd11);
    end
    step(1'b1, 5'd20, 32'h999, 1'b1, 5'd20, 5'd14);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd11, 5'd14);

    // Same register twice under hold: newest wins in forwarding and commit.
    step(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 5'd5);
    step(1'b1, 5'd5, 32'h22, 1'b1, 5'd5, 5'd5);
    step(1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 5'd5);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    check("r5_newest", dutRf[5], 64'h22);

    // Three pending under hold, then reset: none may commit.
    step(1'b1, 5'd7, 32'h5A5A0007, 1'b1, 5'd7, 5'd8);
    step(1'b1, 5'd8, 32'h5A5A0008, 1'b1, 5'd7, 5'd8);
    step(1'b1, 5'd9, 32'h5A5A0009, 1'b1, 5'd9, 5'd8);
    drain_hold = 1'b0;
    doReset();
`else
    // One entry pending at reset: it must be discarded, not committed.
    step(1'b1, 5'd7, 32'h5A5A0007, 1'b0, 5'd7, 5'd8);
    doReset();
`endif
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd9);
    check("r7_not_committed", dutRf[7], 64'(rfModel[7]));

    // Randomized traffic with a small register range to force collisions.
    for (int n = 0; n < 300; n++) begin
      logic rh;
`ifdef REGFILE_WB_HOLD_EN
      rh = ($urandom_range(0, 3) == 0);
`else
      rh = 1'b0;
`endif
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, rh,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int n = 0; n < DEPTH + 1; n++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 32; i++) begin
      check("final_rf", dutRf[i], 64'(rfModel[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
